// File: rtl/md_controller.sv
// md_controller: multi-cycle mult/div sequencer holding HI/LO and raising the E-stage MD stall
module md_controller #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_is_md,
  output logic        E_MD_stall,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);
  logic [31:0] hi_tmp, lo_tmp;
  logic [3:0]  cnt;
  logic        is_mul, is_div, is_issue, sgn_mul, sgn_div;
  logic [63:0] a64, b64, prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rmd, res_hi, res_lo;
  // Decode, result datapath and the combinational stall/read outputs
  always_comb begin
    is_mul = E_md_op == 4'd1 || E_md_op == 4'd2;
    is_div = E_md_op == 4'd3 || E_md_op == 4'd4;
    is_issue = is_mul || is_div;
    busy = cnt != 4'd0;
    E_MD_stall = D_is_md && (busy || is_issue);
    md_out = busy ? 32'd0 : E_md_op == 4'd7 ? hi : E_md_op == 4'd8 ? lo : 32'd0;
    sgn_mul = E_md_op == 4'd1;
    a64 = {sgn_mul ? {32{E_A[31]}} : 32'd0, E_A};
    b64 = {sgn_mul ? {32{E_B[31]}} : 32'd0, E_B};
    prod = a64 * b64;
    sgn_div = E_md_op == 4'd3;
    a_mag = sgn_div && E_A[31] ? -E_A : E_A;
    b_mag = sgn_div && E_B[31] ? -E_B : E_B;
    q_mag = b_mag == 32'd0 ? 32'd0 : a_mag / b_mag;
    r_mag = b_mag == 32'd0 ? 32'd0 : a_mag % b_mag;
    quo = sgn_div && (E_A[31] ^ E_B[31]) ? -q_mag : q_mag;
    rmd = sgn_div && E_A[31] ? -r_mag : r_mag;
    res_hi = is_mul ? prod[63:32] : E_B == 32'd0 ? hi : rmd;
    res_lo = is_mul ? prod[31:0] : E_B == 32'd0 ? lo : quo;
  end
  // Busy countdown with commit on expiry; issue and HI/LO moves only when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= 32'd0;
      lo <= 32'd0;
      hi_tmp <= 32'd0;
      lo_tmp <= 32'd0;
      cnt <= 4'd0;
    end else if (busy) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        hi <= hi_tmp;
        lo <= lo_tmp;
      end
    end else if (is_issue) begin
      cnt <= is_mul ? MULT_LAT : DIV_LAT;
      hi_tmp <= res_hi;
      lo_tmp <= res_lo;
    end else if (E_md_op == 4'd5) begin
      hi <= E_A;
    end else if (E_md_op == 4'd6) begin
      lo <= E_A;
    end
  end
endmodule
